// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM stage bus: EX/MEM register outputs in, branch/stall and MEM/WB register outputs out.
interface mem_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             mem_read_im;
  logic             mem_write_im;
  logic             branch_im;
  logic             zero_im;
  logic [WIDTH-1:0] alu_out_im32;
  logic [WIDTH-1:0] write_data_im32;
  logic [4:0]       dst_reg_addr_im5;
  logic             reg_write_im;
  logic             mem_to_reg_im;
  logic [WIDTH-1:0] pc_branch_im32;

  logic             pc_src_o;
  logic [WIDTH-1:0] pc_branch_o32;
  logic             stall_o;
  logic [WIDTH-1:0] read_data_ow32;
  logic [WIDTH-1:0] alu_out_ow32;
  logic [4:0]       dst_reg_addr_ow5;
  logic             reg_write_ow;
  logic             mem_to_reg_ow;
  logic             misalign_ow;

  modport master (
    output mem_read_im, mem_write_im, branch_im, zero_im, alu_out_im32,
           write_data_im32, dst_reg_addr_im5, reg_write_im, mem_to_reg_im,
           pc_branch_im32,
    input  pc_src_o, pc_branch_o32, stall_o, read_data_ow32, alu_out_ow32,
           dst_reg_addr_ow5, reg_write_ow, mem_to_reg_ow, misalign_ow
  );

  modport slave (
    input  mem_read_im, mem_write_im, branch_im, zero_im, alu_out_im32,
           write_data_im32, dst_reg_addr_im5, reg_write_im, mem_to_reg_im,
           pc_branch_im32,
    output pc_src_o, pc_branch_o32, stall_o, read_data_ow32, alu_out_ow32,
           dst_reg_addr_ow5, reg_write_ow, mem_to_reg_ow, misalign_ow
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory stage: word data memory with MEM_LAT-cycle access, branch resolve, MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses suppress the store/writeback and flag misalign_ow.
module mem_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  mem_stage_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             access_c;
  logic             stall_c;
  logic             complete_c;
  logic             misalign_c;
  logic             store_c;
  logic [AW-1:0]    idx_c;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] read_data_q;
  logic [WIDTH-1:0] alu_out_q;
  logic [4:0]       dst_reg_addr_q;
  logic             reg_write_q;
  logic             mem_to_reg_q;
  logic             misalign_q;

  assign access_c   = bus.mem_read_im | bus.mem_write_im;
  assign stall_c    = access_c & (cnt_q != CNT_LAST);
  assign complete_c = ~stall_c;
  assign idx_c      = bus.alu_out_im32[2 +: AW];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_c = access_c & (bus.alu_out_im32[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  assign store_c = bus.mem_write_im & complete_c & ~misalign_c;

  // Branch resolution is purely combinational and ignores stall.
  assign bus.pc_src_o      = bus.branch_im & bus.zero_im;
  assign bus.pc_branch_o32 = bus.pc_branch_im32;
  assign bus.stall_o       = stall_c;

  // Access-latency FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Access-latency FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (stall_c) begin
          state_d = BUSY;
          cnt_d   = CW'(1);
        end
      end
      BUSY: begin
        // A dropped access mid-sequence abandons it rather than completing.
        if (!access_c || !stall_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Data memory: contents are not reset
  always_ff @(posedge clk_i) begin
    if (store_c) begin
      mem[idx_c] <= bus.write_data_im32;
    end
  end

  // MEM/WB register: capture on completion, bubble while stalled
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      read_data_q    <= '0;
      alu_out_q      <= '0;
      dst_reg_addr_q <= '0;
      reg_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      misalign_q     <= 1'b0;
    end else if (complete_c) begin
      read_data_q    <= mem[idx_c];
      alu_out_q      <= bus.alu_out_im32;
      dst_reg_addr_q <= bus.dst_reg_addr_im5;
      reg_write_q    <= bus.reg_write_im & ~misalign_c;
      mem_to_reg_q   <= bus.mem_to_reg_im;
      misalign_q     <= misalign_c;
    end else begin
      reg_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      misalign_q     <= 1'b0;
    end
  end

  assign bus.read_data_ow32   = read_data_q;
  assign bus.alu_out_ow32     = alu_out_q;
  assign bus.dst_reg_addr_ow5 = dst_reg_addr_q;
  assign bus.reg_write_ow     = reg_write_q;
  assign bus.mem_to_reg_ow    = mem_to_reg_q;
  assign bus.misalign_ow      = misalign_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the pipelined MIPS core, directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM register outputs, performs word load/store against an internal data memory with configurable access latency, and resolves branches.
- Contains the MEM/WB pipeline register feeding writeback.
- Asserts a stall to the hazard unit while a multi-cycle access is in progress.

Parameters:
WIDTH, 32, datapath width (data and address)
DEPTH, 64, data memory depth in words (power of two)
MEM_LAT, 1, cycles per load/store (>=1); 1 = single-cycle, never stalls

Ports:
clk_i  in  1  clock
reset_i  in  1  reset
mem_read_im  in  1  load in MEM
mem_write_im  in  1  store in MEM
branch_im  in  1  branch instruction in MEM
zero_im  in  1  ALU zero flag from EX/MEM
alu_out_im32  in  WIDTH  ALU result / byte address
write_data_im32  in  WIDTH  store data
dst_reg_addr_im5  in  5  destination register
reg_write_im  in  1  writeback enable
mem_to_reg_im  in  1  writeback selects load data
pc_branch_im32  in  WIDTH  branch target
pc_src_o  out  1  take branch (combinational)
pc_branch_o32  out  WIDTH  branch target to fetch (combinational passthrough)
stall_o  out  1  hold IF..EX/MEM this cycle (combinational)
read_data_ow32  out  WIDTH  MEM/WB load data
alu_out_ow32  out  WIDTH  MEM/WB ALU result
dst_reg_addr_ow5  out  5  MEM/WB destination
reg_write_ow  out  1  MEM/WB writeback enable
mem_to_reg_ow  out  1  MEM/WB select
misalign_ow  out  1  MEM/WB misalignment flag (see Optional Feature)

Behaviour:
- Reset reset_i, asynchronous, active-high; clock clk_i. Reset clears all MEM/WB outputs to 0, FSM to IDLE, counter to 0. Memory contents are not reset.
- pc_src_o = branch_im & zero_im. pc_branch_o32 = pc_branch_im32. Both are independent of stall.
- access = mem_read_im | mem_write_im.
- Word index = alu_out_im32[2 +: log2(DEPTH)]. Upper bits are ignored, so addresses wrap modulo DEPTH words.
- FSM states IDLE and BUSY, with counter cnt (width clog2(MEM_LAT)+1):
  - stall_o = access & (cnt != MEM_LAT-1). Always 0 when MEM_LAT=1.
  - IDLE: if access & stall_o, go to BUSY with cnt <= 1. Otherwise stay in IDLE.
  - BUSY: cnt increments each cycle while stall_o=1. On the completion cycle (cnt == MEM_LAT-1), go to IDLE with cnt <= 0.
  - Upstream holds its inputs while stall_o=1. If access drops while in BUSY (only possible via reset/upstream fault), return to IDLE with cnt <= 0.
- Completion cycle is any non-stalled cycle. At its rising edge:
  - Store: mem[idx] <= write_data_im32.
  - MEM/WB captures: read_data_ow32 <= mem[idx], pre-write contents; alu_out, dst, reg_write, mem_to_reg.
- Stalled cycle: MEM/WB receives a bubble. reg_write_ow <= 0 and mem_to_reg_ow <= 0; other MEM/WB fields hold.
- Total latency:
  - Non-memory instruction: 1 edge.
  - Load/store: MEM_LAT edges, with stall_o high for exactly MEM_LAT-1 cycles.
- mem_read_im and mem_write_im both high: the store commits, and read data returns the pre-write contents.
- Store followed immediately by load to the same word: the load sees the new data.
- Reset mid-access: a pending store is discarded (memory unchanged), FSM returns to IDLE, outputs clear.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - On a completion cycle with access & (alu_out_im32[1:0] != 0), the store is suppressed.
  - MEM/WB receives reg_write_ow=0 and misalign_ow=1 for one cycle. misalign_ow=0 otherwise.
  - The stall sequence is unchanged.
- Not defined:
  - Address bits [1:0] are ignored and the access proceeds on the aligned word.
  - misalign_ow is tied to 0.

Test Plan:
- Reset, then non-memory op (alu_out=0x0000_0010, dst=5, reg_write=1) -> next edge alu_out_ow32=0x10, dst_reg_addr_ow5=5, reg_write_ow=1, stall_o=0.
- MEM_LAT=1: store 0xDEADBEEF at 0x8, then load 0x8 with mem_to_reg=1, dst=9 -> read_data_ow32=0xDEADBEEF, mem_to_reg_ow=1, no stall.
- MEM_LAT=3: load at 0x4 -> stall_o high exactly 2 cycles, reg_write_ow=0 during bubbles, data valid after 3rd edge.
- Wrap: DEPTH=64, store 0x1234 at 0x104 (index 1), load 0x4 -> 0x1234.
- branch_im=1, zero_im=1, pc_branch=0x40 -> pc_src_o=1, pc_branch_o32=0x40 same cycle. With zero_im=0 -> pc_src_o=0.
- MEM_LAT=3: assert reset_i during 2nd stall cycle of store 0x55 to 0xC -> outputs 0, stall_o=0, subsequent load of 0xC returns the prior contents. With MEM_MISALIGN_TRAP_EN: store to 0x6 -> memory unchanged, misalign_ow=1 for one cycle.
